uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 The parameter MAGICNUMBER, default 32'hDABBAD00, SHALL be the 4-byte frame header, matched first byte = bits [31:24].
REQ-002 The parameter PAYLOAD_BYTES, default 2, range 1..16, SHALL be the payload bytes per frame.
REQ-003 The parameter TIMEOUT_CYCLES, default 16000 (1 ms at 16 MHz), SHALL be the maximum number of CLK cycles allowed between bytes inside a frame.
REQ-004 The port CLK SHALL be: input, 1 bit, the single clock (16 MHz).
REQ-005 The port RST_N SHALL be: input, 1 bit, reset, asynchronous, active-low.
REQ-006 The port rx_data_ready SHALL be: input, 1 bit, one-cycle strobe from uart_rx marking rx_data valid.
REQ-007 The port rx_data SHALL be: input, 8 bits, received byte.
REQ-008 The port payload SHALL be: output, PAYLOAD_BYTES*8 bits, last good payload, first byte in bits [7:0].
REQ-009 The port frame_valid SHALL be: output, 1 bit, one-cycle pulse when payload is updated.
REQ-010 The port crc_error SHALL be: output, 1 bit, one-cycle pulse on CRC mismatch.
REQ-011 The port timeout_error SHALL be: output, 1 bit, one-cycle pulse on inter-byte timeout.
REQ-012 The port busy SHALL be: output, 1 bit, high whenever state is not HUNT.
REQ-013 The port frame_count SHALL be: output, 16 bits, good-frame counter.
REQ-014 The port error_count SHALL be: output, 8 bits, CRC-plus-timeout error counter.

Function
REQ-015 The FSM SHALL have the states HUNT, PAYLOAD, CRC_HI and CRC_LO; every transition SHALL occur only on a sampled rx_data_ready strobe or on a timeout.
REQ-016 In HUNT, each strobe SHALL shift rx_data into a 4-byte header register, newest byte last.
REQ-017 In HUNT, when the shifted-in value equals MAGICNUMBER, the FSM SHALL move to PAYLOAD, clear the header register, clear the byte index, and preset the CRC to 16'hFFFF.
REQ-018 Overlapping header patterns SHALL be detected correctly, e.g. DA DA BB AD 00 matches.
REQ-019 In PAYLOAD, each strobe SHALL store the byte at the byte index into a staging buffer and advance the CRC.
REQ-020 In PAYLOAD, after byte PAYLOAD_BYTES-1 the FSM SHALL move to CRC_HI.
REQ-021 The CRC SHALL be CRC-16/CCITT-FALSE: polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
REQ-022 The CRC SHALL cover only the payload bytes and SHALL be updated one full byte per strobe, in a single cycle.
REQ-023 In CRC_HI, the strobe SHALL latch the received CRC high byte and the FSM SHALL move to CRC_LO.
REQ-024 In CRC_LO, on the strobe, if {crc_hi, rx_data} equals the computed CRC: the staging buffer SHALL be copied to payload, frame_valid SHALL pulse, and frame_count SHALL increment.
REQ-025 On a CRC match, frame_count SHALL wrap from 16'hFFFF to 0.
REQ-026 In CRC_LO, on a CRC mismatch, crc_error SHALL pulse, error_count SHALL increment, and payload SHALL be unchanged.
REQ-027 In CRC_LO, after the comparison, the FSM SHALL return to HUNT in both the match and mismatch cases.
REQ-028 frame_valid and crc_error SHALL be registered and SHALL be high exactly in the cycle after the final CRC strobe is sampled.
REQ-029 frame_valid and crc_error SHALL never be high in the same cycle.
REQ-030 The inter-byte counter SHALL clear on every strobe and on entry to PAYLOAD, and SHALL count CLK cycles in all states except HUNT.
REQ-031 When the inter-byte counter reaches TIMEOUT_CYCLES, timeout_error SHALL pulse, error_count SHALL increment, and the FSM SHALL go to HUNT.
REQ-032 On a timeout, the byte of a strobe arriving in that same cycle SHALL be discarded.
REQ-033 error_count SHALL saturate at 8'hFF.
REQ-034 A CRC error and a timeout SHALL never both count for the same frame.
REQ-035 Payload bytes equal to header bytes SHALL NOT cause resynchronisation while in PAYLOAD, CRC_HI or CRC_LO.
REQ-036 Strobes SHALL be at most one per cycle; back-to-back strobes in consecutive cycles SHALL each be accepted.

Reset
REQ-037 Asserting RST_N low SHALL immediately, and including mid-frame, force: state HUNT, header register 0, CRC 16'hFFFF, inter-byte counter 0, payload 0, frame_valid 0, crc_error 0, timeout_error 0, busy 0, frame_count 0, error_count 0.
REQ-038 After RST_N is released, the first strobe SHALL be processed normally in HUNT.

Structure
REQ-039 The CRC polynomial, the CRC init value, the default magic number and the FSM state encodings SHALL live in a shared package used by the frame transmitter as well.
REQ-040 The CRC byte-update logic SHALL be the combinational sub-module frame_crc16 (inputs crc_in and data_in, output crc_out), reused by the transmitter.

Verification
REQ-041 The bench SHALL apply PAYLOAD_BYTES=9 with stream DA BB AD 00 31 32 33 34 35 36 37 38 39 29 B1 and SHALL require: one frame_valid pulse, payload = 0x393837363534333231, frame_count=1.
REQ-042 The bench SHALL apply the same stream with the last byte B0 and SHALL require: crc_error pulse, error_count=1, payload unchanged, frame_valid never high.
REQ-043 The bench SHALL prefix that good frame with garbage 00 DA DA BB AD 00, the extra DA giving an overlapping header, and SHALL require: exactly one frame_valid pulse with the correct payload.
REQ-044 The bench SHALL stop the stream after 3 payload bytes for TIMEOUT_CYCLES cycles and SHALL require: timeout_error pulse, busy=0; a following full good frame SHALL then give frame_valid.
REQ-045 The bench SHALL assert RST_N low after the CRC_HI byte, release it, then send a good frame, and SHALL require: all outputs 0 during reset and exactly one frame_valid after release.
REQ-046 The bench SHALL send 257 bad-CRC frames and SHALL require error_count to hold at 8'hFF.

Source files
------------

// File: rtl/uart_frame_rx_pkg.sv
// rtl/uart_frame_rx_pkg.sv - shared frame constants and FSM encoding for the frame rx/tx pair
package uart_frame_rx_pkg;

  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [31:0] DEFAULT_MAGIC = 32'hDABBAD00;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_HI  = 2'd2,
    CRC_LO  = 2'd3
  } frame_state_t;

endpackage

// File: rtl/frame_crc16.sv
// rtl/frame_crc16.sv - one-byte CRC-16/CCITT-FALSE update, MSB first, purely combinational
module frame_crc16
  import uart_frame_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ data_in[i])
        crc_out = {crc_out[14:0], 1'b0} ^ CRC_POLY;
      else
        crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - byte-stream frame receiver: header hunt, payload capture, CRC check, timeout
module uart_frame_rx
  import uart_frame_rx_pkg::*;
#(
  parameter logic [31:0] MAGICNUMBER    = DEFAULT_MAGIC,
  parameter int          PAYLOAD_BYTES  = 2,
  parameter int          TIMEOUT_CYCLES = 16000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       rx_data_ready,
  input  logic [7:0]                 rx_data,
  output logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       frame_valid,
  output logic                       crc_error,
  output logic                       timeout_error,
  output logic                       busy,
  output logic [15:0]                frame_count,
  output logic [7:0]                 error_count
);

  localparam int IW = $clog2(PAYLOAD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  frame_state_t               state, state_nxt;
  logic [31:0]                hdr;
  logic [31:0]                hdr_shift;
  logic [IW-1:0]              idx;
  logic [15:0]                crc;
  logic [15:0]                crc_nxt;
  logic [7:0]                 crc_hi;
  logic [PAYLOAD_BYTES*8-1:0] stage;
  logic [TW-1:0]              gap_cnt;
  logic                       timeout;
  logic                       strobe;
  logic                       hdr_hit;
  logic                       crc_match;
  logic                       frame_good;
  logic                       frame_bad;

  frame_crc16 u_crc (
    .crc_in  (crc),
    .data_in (rx_data),
    .crc_out (crc_nxt)
  );

  // A timeout wins over a strobe landing in the same cycle; that byte is dropped.
  assign timeout   = (state != HUNT) && (gap_cnt == TW'(TIMEOUT_CYCLES));
  assign strobe    = rx_data_ready && !timeout;
  assign hdr_shift = {hdr[23:0], rx_data};
  assign hdr_hit   = (hdr_shift == MAGICNUMBER);
  assign crc_match = ({crc_hi, rx_data} == crc);
  assign busy      = (state != HUNT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (timeout) begin
      state_nxt = HUNT;
    end else if (strobe) begin
      case (state)
        HUNT:    if (hdr_hit) state_nxt = PAYLOAD;
        PAYLOAD: if (idx == IW'(PAYLOAD_BYTES - 1)) state_nxt = CRC_HI;
        CRC_HI:  state_nxt = CRC_LO;
        CRC_LO: begin
          state_nxt  = HUNT;
          frame_good = crc_match;
          frame_bad  = !crc_match;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hdr           <= '0;
      idx           <= '0;
      crc           <= CRC_INIT;
      crc_hi        <= '0;
      stage         <= '0;
      gap_cnt       <= '0;
      payload       <= '0;
      frame_valid   <= 1'b0;
      crc_error     <= 1'b0;
      timeout_error <= 1'b0;
      frame_count   <= '0;
      error_count   <= '0;
    end else begin
      frame_valid   <= frame_good;
      crc_error     <= frame_bad;
      timeout_error <= timeout;

      if (state == HUNT || rx_data_ready || timeout) gap_cnt <= '0;
      else                                          gap_cnt <= gap_cnt + 1'b1;

      if (strobe) begin
        case (state)
          HUNT: begin
            if (hdr_hit) begin
              hdr <= '0;
              idx <= '0;
              crc <= CRC_INIT;
            end else begin
              hdr <= hdr_shift;
            end
          end
          PAYLOAD: begin
            stage[8*idx +: 8] <= rx_data;
            crc               <= crc_nxt;
            idx               <= idx + 1'b1;
          end
          CRC_HI:  crc_hi <= rx_data;
          default: ;
        endcase
      end

      if (frame_good) begin
        payload     <= stage;
        frame_count <= frame_count + 1'b1;
      end
      if ((frame_bad || timeout) && error_count != 8'hFF)
        error_count <= error_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb/tb_uart_frame_rx.sv - self-checking bench for uart_frame_rx with a stream-level reference model
module tb_uart_frame_rx;

  localparam int          PB    = 9;
  localparam int          TO    = 40;
  localparam logic [31:0] MAGIC = 32'hDABBAD00;
  localparam logic [PB*8-1:0] P123 = 72'h393837363534333231;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [PB*8-1:0] pay;
    bit              bad;
    bit              burst;
    bit              exp_fv;
    logic [PB*8-1:0] exp_pay;
  } vec_t;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            rx_data_ready = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic [PB*8-1:0] payload;
  logic            frame_valid, crc_error, timeout_error, busy;
  logic [15:0]     frame_count;
  logic [7:0]      error_count;

  int n_chk = 0, n_fail = 0;
  int fv_pulses = 0, ce_pulses = 0, te_pulses = 0, both_seen = 0;

  logic [15:0]     exp_fc;
  int              exp_ec;
  logic [PB*8-1:0] exp_pay;

  always #5 CLK = ~CLK;

  uart_frame_rx #(
    .MAGICNUMBER   (MAGIC),
    .PAYLOAD_BYTES (PB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .rx_data_ready(rx_data_ready),
    .rx_data      (rx_data),
    .payload      (payload),
    .frame_valid  (frame_valid),
    .crc_error    (crc_error),
    .timeout_error(timeout_error),
    .busy         (busy),
    .frame_count  (frame_count),
    .error_count  (error_count)
  );

  always @(negedge CLK) begin
    if (frame_valid)              fv_pulses++;
    if (crc_error)                ce_pulses++;
    if (timeout_error)            te_pulses++;
    if (frame_valid && crc_error) both_seen++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit burst);
    rx_data       = b;
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    if (!burst) step();
  endtask

  // Reference CRC straight from the CCITT-FALSE definition over the whole payload.
  function automatic logic [15:0] ref_crc(input logic [PB*8-1:0] p);
    logic [15:0] r = 16'hFFFF;
    for (int k = 0; k < PB; k++)
      for (int b = 7; b >= 0; b--)
        r = (r[15] ^ p[8*k+b]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic bq_t build_frame(input logic [PB*8-1:0] p, input logic [15:0] c);
    bq_t s;
    for (int k = 3; k >= 0; k--) s.push_back(MAGIC[8*k +: 8]);
    for (int k = 0; k < PB; k++) s.push_back(p[8*k +: 8]);
    s.push_back(c[15:8]);
    s.push_back(c[7:0]);
    return s;
  endfunction

  // Scans a byte stream for headers and judges each complete frame it finds.
  task automatic model_stream(input bq_t s);
    int i = 0;
    logic [PB*8-1:0] p;
    logic [15:0] c;
    while (i + 4 <= s.size()) begin
      if ({s[i], s[i+1], s[i+2], s[i+3]} == MAGIC && i + 6 + PB <= s.size()) begin
        for (int k = 0; k < PB; k++) p[8*k +: 8] = s[i+4+k];
        c = {s[i+4+PB], s[i+5+PB]};
        if (c == ref_crc(p)) begin
          exp_pay = p;
          exp_fc++;
        end else if (exp_ec != 255) begin
          exp_ec++;
        end
        i += 6 + PB;
      end else begin
        i++;
      end
    end
  endtask

  task automatic send_q(input bq_t s, input bit burst, input bit exp_fv, input bit exp_ce, input string name);
    for (int k = 0; k < s.size() - 1; k++) send(s[k], burst);
    rx_data       = s[s.size()-1];
    rx_data_ready = 1'b1;
    step();
    rx_data_ready = 1'b0;
    chk({name, "_fv"}, frame_valid, exp_fv);
    chk({name, "_ce"}, crc_error, exp_ce);
    step();
    step();
  endtask

  task automatic chk_state(input string name);
    chk({name, "_payload"}, payload, exp_pay);
    chk({name, "_frame_count"}, frame_count, exp_fc);
    chk({name, "_error_count"}, error_count, exp_ec[7:0]);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_payload"}, payload, 0);
    chk({name, "_fv"}, frame_valid, 0);
    chk({name, "_ce"}, crc_error, 0);
    chk({name, "_te"}, timeout_error, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_fc"}, frame_count, 0);
    chk({name, "_ec"}, error_count, 0);
  endtask

  initial begin
    vec_t vt[5];
    bq_t  s;
    logic [PB*8-1:0] p, p2;
    int   base, lat;
    bit   got, burst, bad, exp_fv;
    logic [15:0] old_fc;

    exp_fc  = 0;
    exp_ec  = 0;
    exp_pay = '0;

    step(); step(); step();
    chk_zero("reset");
    RST_N = 1'b1;
    step();

    // Reference frame "123456789" with its published check value 0x29B1.
    send_q(build_frame(P123, 16'h29B1), 1'b0, 1'b1, 1'b0, "good");
    exp_pay = P123; exp_fc = 1;
    chk_state("good");
    chk("good_fv_pulses", fv_pulses, 1);

    send_q(build_frame(P123, 16'h29B0), 1'b0, 1'b0, 1'b1, "badcrc");
    exp_ec = 1;
    chk_state("badcrc");
    chk("badcrc_fv_pulses", fv_pulses, 1);
    chk("badcrc_ce_pulses", ce_pulses, 1);

    send(8'h00, 1'b0);
    send(8'hDA, 1'b0);
    send_q(build_frame(P123, 16'h29B1), 1'b0, 1'b1, 1'b0, "overlap");
    exp_fc = 2;
    chk_state("overlap");
    chk("overlap_fv_pulses", fv_pulses, 2);

    s = build_frame(P123, 16'h29B1);
    for (int k = 0; k < 7; k++) send(s[k], 1'b0);
    chk("to_busy_before", busy, 1);
    lat = 0; got = 0;
    for (int c = 0; c < TO + 10 && !got; c++) begin
      step();
      lat++;
      if (timeout_error) begin
        got = 1;
        chk("to_busy_at_pulse", busy, 0);
      end
    end
    chk("to_seen", got, 1);
    chk("to_latency_in_range", (lat >= TO && lat <= TO + 2), 1);
    chk("to_pulses", te_pulses, 1);
    exp_ec = 2;
    chk_state("to");
    p2 = 72'h0102030405060708A5;
    send_q(build_frame(p2, ref_crc(p2)), 1'b0, 1'b1, 1'b0, "after_to");
    exp_pay = p2; exp_fc = 3;
    chk_state("after_to");

    for (int k = 0; k < 4 + PB + 1; k++) send(s[k], 1'b0);
    chk("rst_busy_before", busy, 1);
    RST_N = 1'b0;
    #1;
    chk_zero("midrst");
    step();
    chk_zero("midrst_held");
    RST_N = 1'b1;
    step();
    exp_fc = 0; exp_ec = 0; exp_pay = '0;
    base = fv_pulses;
    send_q(build_frame(P123, 16'h29B1), 1'b0, 1'b1, 1'b0, "post_rst");
    exp_pay = P123; exp_fc = 1;
    chk_state("post_rst");
    chk("post_rst_fv_pulses", fv_pulses - base, 1);

    vt[0] = '{72'h00ADBBDA00ADBBDA11, 1'b0, 1'b0, 1'b1, 72'h00ADBBDA00ADBBDA11};
    vt[1] = '{72'h000000000000000000, 1'b0, 1'b1, 1'b1, 72'h000000000000000000};
    vt[2] = '{72'hFFFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 72'h000000000000000000};
    vt[3] = '{72'h0908070605040302DA, 1'b1, 1'b1, 1'b0, 72'h000000000000000000};
    vt[4] = '{72'hDABBAD00DABBAD0099, 1'b0, 1'b1, 1'b1, 72'hDABBAD00DABBAD0099};
    for (int v = 0; v < 5; v++) begin
      send_q(build_frame(vt[v].pay, ref_crc(vt[v].pay) ^ (vt[v].bad ? 16'h0100 : 16'h0000)),
             vt[v].burst, vt[v].exp_fv, !vt[v].exp_fv, $sformatf("vec%0d", v));
      if (vt[v].exp_fv) exp_fc++;
      else              exp_ec++;
      exp_pay = vt[v].exp_pay;
      chk_state($sformatf("vec%0d", v));
    end

    for (int n = 0; n < 40; n++) begin
      s = {};
      for (int g = $urandom_range(0, 5); g > 0; g--) begin
        p[7:0] = 8'($urandom_range(0, 255));
        s.push_back(p[7:0] == 8'hDA ? 8'h5A : p[7:0]);
      end
      for (int k = 0; k < PB; k++) p[8*k +: 8] = 8'($urandom_range(0, 255));
      bad   = ($urandom_range(0, 3) == 0);
      burst = $urandom_range(0, 1) == 1;
      begin
        bq_t f = build_frame(p, ref_crc(p) ^ (bad ? 16'($urandom_range(1, 65535)) : 16'h0000));
        foreach (f[k]) s.push_back(f[k]);
      end
      old_fc = exp_fc;
      model_stream(s);
      exp_fv = (exp_fc != old_fc);
      send_q(s, burst, exp_fv, !exp_fv, $sformatf("rnd%0d", n));
      chk_state($sformatf("rnd%0d", n));
    end

    for (int n = 0; n < 257; n++) begin
      s = build_frame(P123, 16'h1234);
      model_stream(s);
      send_q(s, 1'b1, 1'b0, 1'b1, "sat");
    end
    chk_state("sat");
    chk("sat_ec_ff", error_count, 8'hFF);
    chk("never_both", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
